dram_cmd_sched: RTL and testbench

In-order DDR4 command scheduler that sits directly downstream of the request queue. It accepts one memory request at a time and decodes its address into bank group, bank, row and column. It tracks open rows and per-bank timing for all 16 banks, then issues the required PRE/ACT/RD/WR command sequence on DRAM-clock boundaries, with the DRAM clock running at half the CPU clock. It produces the command stream consumed by the trace writer.

---
 rtl/global_defs.sv | 61 ++++++
 rtl/dram_bank_timer.sv | 77 +++++++
 rtl/dram_cmd_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_dram_cmd_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/global_defs.sv
// Shared types, DDR4 address-map bit positions and default timing constants
// for the in-order DRAM command scheduler.
package global_defs;

    typedef enum logic [1:0] {
        CMD_PRE = 2'd0,
        CMD_ACT = 2'd1,
        CMD_RD  = 2'd2,
        CMD_WR  = 2'd3
    } dram_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ACT  = 2'd2,
        ST_RW   = 2'd3
    } sched_state_e;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_IFETCH = 2'd2;

    typedef struct packed {
        logic [1:0]  op;
        logic [32:0] address;
    } parser_out_struct;

    localparam int ROW_W    = 15;
    localparam int COL_W    = 11;
    localparam int CNT_W    = 8;
    localparam int NBANKS   = 16;

    localparam int ROW_MSB  = 32;
    localparam int ROW_LSB  = 18;
    localparam int COLH_MSB = 17;
    localparam int COLH_LSB = 10;
    localparam int BANK_MSB = 9;
    localparam int BANK_LSB = 8;
    localparam int BG_MSB   = 7;
    localparam int BG_LSB   = 6;
    localparam int COLL_MSB = 5;
    localparam int COLL_LSB = 3;

    localparam int T_RCD_DEF = 24;
    localparam int T_RP_DEF  = 24;
    localparam int T_RAS_DEF = 52;
    localparam int T_RTP_DEF = 12;
    localparam int T_WR_DEF  = 20;
    localparam int T_CCD_DEF = 8;

    // Counters are checked before they decrement on the same edge, so loading
    // 2*T-1 makes the follow-on command land exactly 2*T CPU cycles later.
    function automatic logic [CNT_W-1:0] cpu_wait(input int t_dram);
        int v;
        v = 2 * t_dram - 1;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/dram_bank_timer.sv
// Per-bank open-row state and PRE/ACT/RW wait counters (CPU-cycle units,
// saturating at zero).
module dram_bank_timer
    import global_defs::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pre_issue_i,
    input  logic             act_issue_i,
    input  logic             rw_issue_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [CNT_W-1:0] act_ld_i,
    input  logic [CNT_W-1:0] rw_ld_i,
    input  logic [CNT_W-1:0] ras_ld_i,
    input  logic [CNT_W-1:0] rw_pre_ld_i,
    output logic             open_o,
    output logic [ROW_W-1:0] row_o,
    output logic             pre_ok_o,
    output logic             act_ok_o,
    output logic             rw_ok_o
);

    logic             open_q, open_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] rw_q, rw_d;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        pre_d  = sat_dec(pre_q);
        act_d  = sat_dec(act_q);
        rw_d   = sat_dec(rw_q);
        if (pre_issue_i) begin
            open_d = 1'b0;
            act_d  = act_ld_i;
        end
        if (act_issue_i) begin
            open_d = 1'b1;
            row_d  = row_i;
            rw_d   = rw_ld_i;
            pre_d  = ras_ld_i;
        end
        // A read/write may only extend the remaining tRAS window, never shorten it.
        if (rw_issue_i) begin
            pre_d = (pre_d > rw_pre_ld_i) ? pre_d : rw_pre_ld_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            open_q <= 1'b0;
            row_q  <= '0;
            pre_q  <= '0;
            act_q  <= '0;
            rw_q   <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            pre_q  <= pre_d;
            act_q  <= act_d;
            rw_q   <= rw_d;
        end
    end

    assign open_o   = open_q;
    assign row_o    = row_q;
    assign pre_ok_o = (pre_q == '0);
    assign act_ok_o = (act_q == '0);
    assign rw_ok_o  = (rw_q == '0);

endmodule

// File: rtl/dram_cmd_sched.sv
// In-order DDR4 PRE/ACT/RD/WR scheduler, DRAM clock = CPU clock / 2.
// DRAM_CLOSE_PAGE_EN: precharge after every access (close-page policy).
module dram_cmd_sched
    import global_defs::*;
#(
    parameter int T_RCD = T_RCD_DEF,
    parameter int T_RP  = T_RP_DEF,
    parameter int T_RAS = T_RAS_DEF,
    parameter int T_RTP = T_RTP_DEF,
    parameter int T_WR  = T_WR_DEF,
    parameter int T_CCD = T_CCD_DEF
) (
    input  logic             CPU_clock,
    input  logic             rst,
    input  logic             req_valid,
    input  parser_out_struct req,
    output logic             req_ready,
    output logic             cmd_valid,
    output dram_cmd_e        cmd,
    output logic [1:0]       cmd_bg,
    output logic [1:0]       cmd_bank,
    output logic [14:0]      cmd_row,
    output logic [10:0]      cmd_col,
    output logic             req_done
);

    localparam logic [CNT_W-1:0] LD_RCD = cpu_wait(T_RCD);
    localparam logic [CNT_W-1:0] LD_RP  = cpu_wait(T_RP);
    localparam logic [CNT_W-1:0] LD_RAS = cpu_wait(T_RAS);
    localparam logic [CNT_W-1:0] LD_RTP = cpu_wait(T_RTP);
    localparam logic [CNT_W-1:0] LD_WR  = cpu_wait(T_WR);
    localparam logic [CNT_W-1:0] LD_CCD = cpu_wait(T_CCD);

    sched_state_e     state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             wr_q, wr_d;
    logic             rw_done_q, rw_done_d;
    logic [CNT_W-1:0] ccd_q, ccd_d;
    logic             phase_q;

    logic             req_ready_q, req_ready_d;
    logic             cmd_valid_q, cmd_valid_d;
    dram_cmd_e        cmd_q, cmd_d;
    logic [1:0]       bg_q, bg_d;
    logic [1:0]       bank_q, bank_d;
    logic [ROW_W-1:0] crow_q, crow_d;
    logic [COL_W-1:0] ccol_q, ccol_d;
    logic             req_done_q, req_done_d;

    logic             fire_pre, fire_act, fire_rw;
    logic [3:0]       dec_idx;
    logic [ROW_W-1:0] dec_row;
    logic [COL_W-1:0] dec_col;
    logic [CNT_W-1:0] rw_pre_ld;
    logic             unused_addr_lsbs;

    logic [NBANKS-1:0] bank_open;
    logic [NBANKS-1:0] pre_ok;
    logic [NBANKS-1:0] act_ok;
    logic [NBANKS-1:0] rw_ok;
    logic [ROW_W-1:0]  bank_row [NBANKS];

    assign dec_idx          = {req.address[BG_MSB:BG_LSB], req.address[BANK_MSB:BANK_LSB]};
    assign dec_row          = req.address[ROW_MSB:ROW_LSB];
    assign dec_col          = {req.address[COLH_MSB:COLH_LSB], req.address[COLL_MSB:COLL_LSB]};
    assign unused_addr_lsbs = ^req.address[2:0];
    assign rw_pre_ld        = wr_q ? LD_WR : LD_RTP;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        dram_bank_timer u_timer (
            .clk_i       (CPU_clock),
            .rst_i       (rst),
            .pre_issue_i (fire_pre && (idx_q == 4'(b))),
            .act_issue_i (fire_act && (idx_q == 4'(b))),
            .rw_issue_i  (fire_rw && (idx_q == 4'(b))),
            .row_i       (row_q),
            .act_ld_i    (LD_RP),
            .rw_ld_i     (LD_RCD),
            .ras_ld_i    (LD_RAS),
            .rw_pre_ld_i (rw_pre_ld),
            .open_o      (bank_open[b]),
            .row_o       (bank_row[b]),
            .pre_ok_o    (pre_ok[b]),
            .act_ok_o    (act_ok[b]),
            .rw_ok_o     (rw_ok[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        wr_d        = wr_q;
        rw_done_d   = rw_done_q;
        ccd_d       = (ccd_q == '0) ? '0 : ccd_q - 1'b1;
        fire_pre    = 1'b0;
        fire_act    = 1'b0;
        fire_rw     = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        bg_d        = bg_q;
        bank_d      = bank_q;
        crow_d      = crow_q;
        ccol_d      = ccol_q;
        req_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    idx_d     = dec_idx;
                    row_d     = dec_row;
                    col_d     = dec_col;
                    wr_d      = (req.op == OP_WRITE);
                    rw_done_d = 1'b0;
                    if (!bank_open[dec_idx]) begin
                        state_d = ST_ACT;
                    end else if (bank_row[dec_idx] == dec_row) begin
                        state_d = ST_RW;
                    end else begin
                        state_d = ST_PRE;
                    end
                end
            end
            ST_PRE: begin
                if (!phase_q && pre_ok[idx_q]) begin
                    fire_pre    = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_PRE;
                    if (rw_done_q) begin
                        req_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_ACT;
                    end
                end
            end
            ST_ACT: begin
                if (!phase_q && act_ok[idx_q]) begin
                    fire_act    = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_ACT;
                    state_d     = ST_RW;
                end
            end
            ST_RW: begin
                if (!phase_q && rw_ok[idx_q] && (ccd_q == '0)) begin
                    fire_rw     = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_d       = wr_q ? CMD_WR : CMD_RD;
                    ccd_d       = LD_CCD;
`ifdef DRAM_CLOSE_PAGE_EN
                    rw_done_d   = 1'b1;
                    state_d     = ST_PRE;
`else
                    req_done_d  = 1'b1;
                    state_d     = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_valid_d) begin
            bg_d   = idx_q[3:2];
            bank_d = idx_q[1:0];
            crow_d = row_q;
            ccol_d = col_q;
        end
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CPU_clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wr_q        <= 1'b0;
            rw_done_q   <= 1'b0;
            ccd_q       <= '0;
            phase_q     <= 1'b0;
            req_ready_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_PRE;
            bg_q        <= '0;
            bank_q      <= '0;
            crow_q      <= '0;
            ccol_q      <= '0;
            req_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wr_q        <= wr_d;
            rw_done_q   <= rw_done_d;
            ccd_q       <= ccd_d;
            phase_q     <= ~phase_q;
            req_ready_q <= req_ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            bg_q        <= bg_d;
            bank_q      <= bank_d;
            crow_q      <= crow_d;
            ccol_q      <= ccol_d;
            req_done_q  <= req_done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_bg    = bg_q;
    assign cmd_bank  = bank_q;
    assign cmd_row   = crow_q;
    assign cmd_col   = ccol_q;
    assign req_done  = req_done_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched (open-page build) with short timing values.
module tb_dram_cmd_sched;
    import global_defs::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    parser_out_struct req;
    logic             req_ready;
    logic             cmd_valid;
    dram_cmd_e        cmd;
    logic [1:0]       cmd_bg;
    logic [1:0]       cmd_bank;
    logic [14:0]      cmd_row;
    logic [10:0]      cmd_col;
    logic             req_done;

    always #5 clk = ~clk;

    dram_cmd_sched #(
        .T_RCD(2), .T_RP(2), .T_RAS(4), .T_RTP(1), .T_WR(3), .T_CCD(1)
    ) dut (
        .CPU_clock (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req       (req),
        .req_ready (req_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .req_done  (req_done)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [10:0] col;
        logic        done;
    } rec_t;

    rec_t recs[$];
    rec_t mon_r;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   stray_done = 0;
    int   adj_pulse = 0;
    int   acc_cyc = 0;
    logic prev_cv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Command log, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmd_valid) begin
            mon_r.cyc  = cyc;
            mon_r.cmd  = cmd;
            mon_r.bg   = cmd_bg;
            mon_r.bank = cmd_bank;
            mon_r.row  = cmd_row;
            mon_r.col  = cmd_col;
            mon_r.done = req_done;
            recs.push_back(mon_r);
        end
        if (req_done && !cmd_valid) stray_done++;
        if (cmd_valid && prev_cv) adj_pulse++;
        prev_cv = cmd_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic rec_t get_rec(input int i);
        rec_t z;
        z.cyc  = -100000;
        z.cmd  = 'x;
        z.bg   = 'x;
        z.bank = 'x;
        z.row  = 'x;
        z.col  = 'x;
        z.done = 1'bx;
        if (i >= 0 && i < recs.size()) return recs[i];
        return z;
    endfunction

    task automatic offer(input logic [1:0] op, input logic [32:0] addr, input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_ready_wait"}, (n < 200), 1);
        req.op      = op;
        req.address = addr;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic run_req(input logic [1:0] op, input logic [32:0] addr, input string tag);
        int n;
        offer(op, addr, tag);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!req_done && n < 200);
        check({tag, "_done_seen"}, req_done, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   i0, i1, n;
        rec_t r, p, a, d;
        int   prev_cyc, act_cyc;

        rst       = 1'b1;
        req_valid = 1'b0;
        req       = '0;

        // Reset state and idle behaviour
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",     req_ready, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd",       cmd, 0);
        check("rst_row",       cmd_row, 0);
        check("rst_done",      req_done, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("ready_after_rst", req_ready, 1);
        repeat (10) @(negedge clk);
        #1;
        check("idle_no_cmds", recs.size(), 0);

        // Closed-bank read: ACT row 1 then RD col 0, 4 cycles apart
        i0 = recs.size();
        run_req(OP_READ, 33'h0_0004_0000, "s2");
        check("s2_ncmd", recs.size(), i0 + 2);
        a = get_rec(i0);
        d = get_rec(i0 + 1);
        check("s2_act_cmd",  a.cmd, CMD_ACT);
        check("s2_act_row",  a.row, 1);
        check("s2_act_bg",   a.bg, 0);
        check("s2_act_bank", a.bank, 0);
        check("s2_act_done", a.done, 0);
        check("s2_act_lat",  ((a.cyc - acc_cyc) >= 1) && ((a.cyc - acc_cyc) <= 2), 1);
        check("s2_rd_cmd",   d.cmd, CMD_RD);
        check("s2_rd_col",   d.col, 0);
        check("s2_rd_done",  d.done, 1);
        check("s2_act_to_rd", d.cyc - a.cyc, 4);

        // Row hit via ifetch, col 8: RD only
        prev_cyc = d.cyc;
        i0 = recs.size();
        run_req(OP_IFETCH, 33'h0_0004_0400, "s3");
        check("s3_ncmd", recs.size(), i0 + 1);
        r = get_rec(i0);
        check("s3_cmd",    r.cmd, CMD_RD);
        check("s3_col",    r.col, 8);
        check("s3_row",    r.row, 1);
        check("s3_gap_ge2", (r.cyc - prev_cyc) >= 2, 1);

        // Row miss right after ACT on bank 1: tRAS then tRP then tRCD
        i0 = recs.size();
        run_req(OP_READ, 33'h0_0004_0100, "s4a");
        a = get_rec(i0);
        check("s4a_act_cmd",  a.cmd, CMD_ACT);
        check("s4a_act_bank", a.bank, 1);
        act_cyc = a.cyc;
        i1 = recs.size();
        run_req(OP_READ, 33'h0_0008_0100, "s4b");
        check("s4b_ncmd", recs.size(), i1 + 3);
        p = get_rec(i1);
        a = get_rec(i1 + 1);
        d = get_rec(i1 + 2);
        check("s4b_pre_cmd",    p.cmd, CMD_PRE);
        check("s4b_pre_bank",   p.bank, 1);
        check("s4b_pre_ge8",    (p.cyc - act_cyc) >= 8, 1);
        check("s4b_act_cmd",    a.cmd, CMD_ACT);
        check("s4b_act_row",    a.row, 2);
        check("s4b_pre_to_act", a.cyc - p.cyc, 4);
        check("s4b_rd_cmd",     d.cmd, CMD_RD);
        check("s4b_act_to_rd",  d.cyc - a.cyc, 4);

        // Write then row miss on bank 2: write recovery governs the PRE
        i0 = recs.size();
        run_req(OP_WRITE, 33'h0_0004_0200, "s5a");
        d = get_rec(i0 + 1);
        check("s5a_wr_cmd",  d.cmd, CMD_WR);
        check("s5a_wr_bank", d.bank, 2);
        i1 = recs.size();
        run_req(OP_READ, 33'h0_000C_0200, "s5b");
        p = get_rec(i1);
        a = get_rec(i1 + 1);
        check("s5b_pre_cmd", p.cmd, CMD_PRE);
        check("s5b_pre_ge6", (p.cyc - d.cyc) >= 6, 1);
        check("s5b_act_row", a.row, 3);

        // Reset between ACT and RD on bank 3
        i0 = recs.size();
        offer(OP_READ, 33'h0_0004_0300, "s6a");
        n = 0;
        while (recs.size() == i0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        a = get_rec(i0);
        check("s6a_act_cmd",  a.cmd, CMD_ACT);
        check("s6a_act_bank", a.bank, 3);
        rst = 1'b1;
        @(negedge clk); #1;
        check("s6_rst_ready", req_ready, 0);
        check("s6_rst_cv",    cmd_valid, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("s6_no_rd",    recs.size(), i0 + 1);
        check("s6_ready_up", req_ready, 1);
        i1 = recs.size();
        run_req(OP_READ, 33'h0_0004_0300, "s6b");
        check("s6b_ncmd", recs.size(), i1 + 2);
        a = get_rec(i1);
        d = get_rec(i1 + 1);
        check("s6b_act_cmd",  a.cmd, CMD_ACT);
        check("s6b_act_bank", a.bank, 3);
        check("s6b_rd_cmd",   d.cmd, CMD_RD);
        check("s6b_act_to_rd", d.cyc - a.cyc, 4);

        // Pulse shape over the whole run
        check("stray_done", stray_done, 0);
        check("adj_pulse",  adj_pulse, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
